// File: rtl/block_memory_pkg.sv
// Shared encodings and geometry for the brick field and the play controller that drives it.
package block_memory_pkg;

  localparam int unsigned ROWS      = 30;
  localparam int unsigned COLS      = 10;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned ROW_W     = 5;
  localparam int unsigned COL_W     = 5;
  localparam int unsigned STAGE_W   = 2;
  localparam int unsigned REM_W     = 9;
  localparam int unsigned ROW_IDX_W = $clog2(ROWS);
  localparam int unsigned COL_IDX_W = $clog2(COLS);

  // Brick code fields
  localparam int unsigned HP_LSB    = 0;
  localparam int unsigned HP_W      = 2;
  localparam int unsigned WIDE_BIT  = 2;
  localparam int unsigned SOLID_BIT = 3;

  typedef enum logic [1:0] {
    FUNC_HIT  = 2'b00,
    FUNC_LOAD = 2'b01,
    FUNC_PREV = 2'b10,
    FUNC_NEXT = 2'b11
  } func_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  typedef logic [CODE_W-1:0] code_t;

  function automatic logic is_destructible(code_t code);
    return (code != '0) && !code[SOLID_BIT];
  endfunction

endpackage

// File: rtl/block_memory_stage_rom.sv
// Fixed brick layouts for the four stages; pure combinational lookup.
module block_memory_stage_rom
  import block_memory_pkg::*;
(
  input  logic [STAGE_W-1:0]   stage,
  input  logic [ROW_IDX_W-1:0] row,
  input  logic [COL_IDX_W-1:0] col,
  output code_t                code_c
);

  always_comb begin
    code_c = '0;
    unique case (stage)
      2'd0: begin
        if (row >= ROW_IDX_W'(2) && row <= ROW_IDX_W'(5)) code_c = 4'h1;
      end
      2'd1: begin
        // Checkerboard: (row+col) even means the low bits agree
        if (row >= ROW_IDX_W'(2) && row <= ROW_IDX_W'(7) && (row[0] == col[0])) code_c = 4'h2;
      end
      2'd2: begin
        if (row >= ROW_IDX_W'(2) && row <= ROW_IDX_W'(3)) begin
          code_c = 4'h8;
        end else if (row >= ROW_IDX_W'(4) && row <= ROW_IDX_W'(7) && !col[0]) begin
          code_c = 4'h5;
        end
      end
      default: begin
        if (row <= ROW_IDX_W'(9)) code_c = 4'h3;
      end
    endcase
  end

endmodule

// File: rtl/block_memory.sv
// Brick field storage: combinational scan-read port, hit/load/stage-select commands,
// and bricks-remaining / level-cleared status.
module block_memory
  import block_memory_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         func,
  input  logic [STAGE_W-1:0] stage,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  output logic               ready,
  output logic [CODE_W-1:0]  block,
  output logic [STAGE_W-1:0] cur_stage,
  output logic [REM_W-1:0]   remaining,
  output logic               cleared
);

  state_e               state_q, state_d;
  code_t                grid_q [ROWS][COLS];
  code_t                grid_d [ROWS][COLS];
  logic [STAGE_W-1:0]   cur_stage_q, cur_stage_d;
  logic [REM_W-1:0]     remaining_q, remaining_d;
  logic                 loaded_q, loaded_d;
  logic [ROW_IDX_W-1:0] ld_row_q, ld_row_d;
  logic [COL_IDX_W-1:0] ld_col_q, ld_col_d;

  logic                 in_range_c;
  code_t                cell_c;
  code_t                rom_code_c;
  logic [HP_W-1:0]      hp_c;

  block_memory_stage_rom u_stage_rom (
    .stage  (cur_stage_q),
    .row    (ld_row_q),
    .col    (ld_col_q),
    .code_c (rom_code_c)
  );

  assign in_range_c = (row < ROW_W'(ROWS)) && (col < COL_W'(COLS));
  assign cell_c     = in_range_c ? grid_q[ROW_IDX_W'(row)][COL_IDX_W'(col)] : '0;
  assign hp_c       = cell_c[HP_LSB +: HP_W];

  always_comb begin
    state_d     = state_q;
    grid_d      = grid_q;
    cur_stage_d = cur_stage_q;
    remaining_d = remaining_q;
    loaded_d    = loaded_q;
    ld_row_d    = ld_row_q;
    ld_col_d    = ld_col_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (func == FUNC_HIT) begin
            // Solid bricks absorb hits; a brick with hp<=1 is destroyed
            if (is_destructible(cell_c)) begin
              if (hp_c > HP_W'(1)) begin
                grid_d[ROW_IDX_W'(row)][COL_IDX_W'(col)] = cell_c - CODE_W'(1);
              end else begin
                grid_d[ROW_IDX_W'(row)][COL_IDX_W'(col)] = '0;
                if (remaining_q != '0) remaining_d = remaining_q - REM_W'(1);
              end
            end
          end else begin
            if (func == FUNC_LOAD)      cur_stage_d = stage;
            else if (func == FUNC_NEXT) cur_stage_d = cur_stage_q + STAGE_W'(1);
            else                        cur_stage_d = cur_stage_q - STAGE_W'(1);
            remaining_d = '0;
            loaded_d    = 1'b0;
            ld_row_d    = '0;
            ld_col_d    = '0;
            state_d     = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        grid_d[ld_row_q][ld_col_q] = rom_code_c;
        if (is_destructible(rom_code_c)) remaining_d = remaining_q + REM_W'(1);
        if (ld_col_q == COL_IDX_W'(COLS - 1)) begin
          ld_col_d = '0;
          if (ld_row_q == ROW_IDX_W'(ROWS - 1)) begin
            state_d  = ST_IDLE;
            loaded_d = 1'b1;
          end else begin
            ld_row_d = ld_row_q + ROW_IDX_W'(1);
          end
        end else begin
          ld_col_d = ld_col_q + COL_IDX_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grid_q      <= '{default: '0};
      cur_stage_q <= '0;
      remaining_q <= '0;
      loaded_q    <= 1'b0;
      ld_row_q    <= '0;
      ld_col_q    <= '0;
    end else begin
      state_q     <= state_d;
      grid_q      <= grid_d;
      cur_stage_q <= cur_stage_d;
      remaining_q <= remaining_d;
      loaded_q    <= loaded_d;
      ld_row_q    <= ld_row_d;
      ld_col_q    <= ld_col_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign block     = ready ? cell_c : '0;
  assign cur_stage = cur_stage_q;
  assign remaining = remaining_q;
  assign cleared   = loaded_q && (remaining_q == '0) && ready;

endmodule

// File: tb/tb_block_memory.sv
// Self-checking bench for block_memory against a cell-array reference model.
module tb_block_memory;
  import block_memory_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] func;
  logic [1:0] stage;
  logic [4:0] row;
  logic [4:0] col;
  logic       ready;
  logic [3:0] block;
  logic [1:0] cur_stage;
  logic [8:0] remaining;
  logic       cleared;

  int checks = 0;
  int errors = 0;

  int m_grid [30][10];
  int m_rem;
  int m_stage;
  bit m_loaded;

  block_memory dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .func      (func),
    .stage     (stage),
    .row       (row),
    .col       (col),
    .ready     (ready),
    .block     (block),
    .cur_stage (cur_stage),
    .remaining (remaining),
    .cleared   (cleared)
  );

  always #5 clock = ~clock;

  function automatic int ref_code(int s, int r, int c);
    case (s)
      0: return (r >= 2 && r <= 5) ? 1 : 0;
      1: return (r >= 2 && r <= 7 && (r + c) % 2 == 0) ? 2 : 0;
      2: begin
        if (r == 2 || r == 3) return 8;
        if (r >= 4 && r <= 7 && c % 2 == 0) return 5;
        return 0;
      end
      default: return (r <= 9) ? 3 : 0;
    endcase
  endfunction

  function automatic int m_read(int r, int c);
    if (r < 30 && c < 10) return m_grid[r][c];
    return 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++) m_grid[r][c] = 0;
    m_rem = 0; m_stage = 0; m_loaded = 0;
  endtask

  task automatic model_load(int s);
    m_stage = s;
    m_rem   = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++) begin
        m_grid[r][c] = ref_code(s, r, c);
        if (m_grid[r][c] != 0 && m_grid[r][c] < 8) m_rem++;
      end
    m_loaded = 1;
  endtask

  task automatic model_hit(int r, int c);
    int g;
    if (r < 30 && c < 10) begin
      g = m_grid[r][c];
      if (g != 0 && g < 8) begin
        if (g % 4 > 1) m_grid[r][c] = g - 1;
        else begin
          m_grid[r][c] = 0;
          if (m_rem > 0) m_rem--;
        end
      end
    end
  endtask

  // Issue a load-type command and wait it out; optionally spray commands while busy
  task automatic run_load(input logic [1:0] f, input logic [1:0] s, input bit poke, input string name);
    int cnt;
    int ns;
    int bad;
    @(negedge clock);
    enable = 1'b1; func = f; stage = s; row = 5'd2; col = 5'd0;
    @(posedge clock); #1;
    if (!poke) enable = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 400) begin
      if (poke) begin
        func = 2'($urandom); stage = 2'($urandom);
        row = 5'($urandom_range(0, 9)); col = 5'($urandom_range(0, 9));
      end
      if (cnt == 100) begin
        checks++;
        if (block !== 4'd0) begin
          errors++; $display("FAIL %s block_while_busy: got %0d expected 0", name, block);
        end
      end
      @(posedge clock); #1;
      cnt++;
    end
    enable = 1'b0;
    case (f)
      FUNC_LOAD: ns = int'(s);
      FUNC_NEXT: ns = (m_stage + 1) % 4;
      FUNC_PREV: ns = (m_stage + 3) % 4;
      default:   ns = m_stage;
    endcase
    model_load(ns);
    checks++;
    if (cnt != 300) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected 300", name, cnt);
    end
    checks++;
    if (cur_stage !== 2'(m_stage)) begin
      errors++; $display("FAIL %s cur_stage: got %0d expected %0d", name, cur_stage, m_stage);
    end
    checks++;
    if (remaining !== 9'(m_rem)) begin
      errors++; $display("FAIL %s remaining: got %0d expected %0d", name, remaining, m_rem);
    end
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++) begin
        row = 5'(r); col = 5'(c); #1;
        if (block !== 4'(m_grid[r][c]) && bad < 4) begin
          bad++; $display("FAIL %s grid(%0d,%0d): got %0d expected %0d", name, r, c, block, m_grid[r][c]);
        end
      end
    checks++;
    if (bad != 0) errors++;
  endtask

  // One HIT: checks the same-cycle (pre-hit) read, then the post-hit cell and count
  task automatic do_hit(input int r, input int c, input string name);
    @(negedge clock);
    enable = 1'b1; func = FUNC_HIT; row = 5'(r); col = 5'(c);
    #1;
    checks++;
    if (block !== 4'(m_read(r, c))) begin
      errors++; $display("FAIL %s prehit(%0d,%0d): got %0d expected %0d", name, r, c, block, m_read(r, c));
    end
    @(posedge clock); #1;
    enable = 1'b0;
    model_hit(r, c);
    checks++;
    if (block !== 4'(m_read(r, c))) begin
      errors++; $display("FAIL %s posthit(%0d,%0d): got %0d expected %0d", name, r, c, block, m_read(r, c));
    end
    checks++;
    if (remaining !== 9'(m_rem)) begin
      errors++; $display("FAIL %s remaining: got %0d expected %0d", name, remaining, m_rem);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; func = 2'd0; stage = 2'd0; row = 5'd0; col = 5'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", ready); end
    checks++;
    if (cur_stage !== 2'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", cur_stage); end
    checks++;
    if (remaining !== 9'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
    checks++;
    if (cleared !== 1'b0) begin errors++; $display("FAIL reset_cleared: got %0d expected 0", cleared); end
    row = 5'd2; col = 5'd0; #1;
    checks++;
    if (block !== 4'd0) begin errors++; $display("FAIL reset_block: got %0d expected 0", block); end
  endtask

  task automatic test_stage0();
    run_load(FUNC_LOAD, 2'd0, 1'b0, "load0");
    checks++;
    if (remaining !== 9'd40) begin errors++; $display("FAIL s0_remaining: got %0d expected 40", remaining); end
    row = 5'd2; col = 5'd0; #1;
    checks++;
    if (block !== 4'd1) begin errors++; $display("FAIL s0_block_2_0: got %0d expected 1", block); end
    row = 5'd6; #1;
    checks++;
    if (block !== 4'd0) begin errors++; $display("FAIL s0_block_6_0: got %0d expected 0", block); end
    do_hit(3, 4, "s0_hit");
    checks++;
    if (remaining !== 9'd39) begin errors++; $display("FAIL s0_after_hit: got %0d expected 39", remaining); end
    do_hit(3, 4, "s0_rehit");
    do_hit(3, 12, "s0_col_oob");
  endtask

  task automatic test_stage3();
    run_load(FUNC_LOAD, 2'd3, 1'b0, "load3");
    for (int i = 0; i < 3; i++) do_hit(0, 0, "s3_hit");
    checks++;
    if (remaining !== 9'd99) begin errors++; $display("FAIL s3_remaining: got %0d expected 99", remaining); end
  endtask

  task automatic test_stage2();
    run_load(FUNC_LOAD, 2'd2, 1'b0, "load2");
    checks++;
    if (remaining !== 9'd20) begin errors++; $display("FAIL s2_remaining: got %0d expected 20", remaining); end
    do_hit(2, 5, "s2_solid");
    for (int r = 4; r <= 7; r++)
      for (int c = 0; c < 10; c += 2) begin
        if (r == 7 && c == 8) begin
          checks++;
          if (cleared !== 1'b0) begin errors++; $display("FAIL s2_cleared_early: got %0d expected 0", cleared); end
        end
        do_hit(r, c, "s2_clear");
      end
    checks++;
    if (cleared !== 1'b1) begin errors++; $display("FAIL s2_cleared: got %0d expected 1", cleared); end
  endtask

  task automatic test_random_hits();
    run_load(FUNC_LOAD, 2'($urandom_range(0, 3)), 1'b0, "load_rand");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) do_hit($urandom_range(0, 9), $urandom_range(0, 9), "rand_hit");
      else do_hit($urandom_range(0, 31), $urandom_range(0, 31), "rand_hit_any");
    end
    checks++;
    if (cleared !== 1'(m_loaded && m_rem == 0)) begin
      errors++; $display("FAIL rand_cleared: got %0d expected %0d", cleared, (m_loaded && m_rem == 0));
    end
  endtask

  task automatic test_stage_nav();
    run_load(FUNC_LOAD, 2'd3, 1'b0, "nav_load3");
    run_load(FUNC_NEXT, 2'd1, 1'b1, "nav_next");
    checks++;
    if (cur_stage !== 2'd0) begin errors++; $display("FAIL nav_next_stage: got %0d expected 0", cur_stage); end
    run_load(FUNC_PREV, 2'd2, 1'b1, "nav_prev");
    checks++;
    if (cur_stage !== 2'd3) begin errors++; $display("FAIL nav_prev_stage: got %0d expected 3", cur_stage); end
  endtask

  task automatic test_reset_during_load();
    int bad;
    @(negedge clock);
    enable = 1'b1; func = FUNC_LOAD; stage = 2'd1;
    @(posedge clock); #1;
    enable = 1'b0;
    repeat (149) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0d expected 1", ready); end
    checks++;
    if (remaining !== 9'd0) begin errors++; $display("FAIL abort_remaining: got %0d expected 0", remaining); end
    checks++;
    if (cleared !== 1'b0) begin errors++; $display("FAIL abort_cleared: got %0d expected 0", cleared); end
    checks++;
    if (cur_stage !== 2'd0) begin errors++; $display("FAIL abort_stage: got %0d expected 0", cur_stage); end
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++) begin
        row = 5'(r); col = 5'(c); #1;
        if (block !== 4'd0 && bad < 4) begin
          bad++; $display("FAIL abort_grid(%0d,%0d): got %0d expected 0", r, c, block);
        end
      end
    checks++;
    if (bad != 0) errors++;
    do_hit(31, 0, "abort_hit_oob");
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL oob_ready: got %0d expected 1", ready); end
  endtask

  initial begin
    test_reset();
    test_stage0();
    test_stage3();
    test_stage2();
    test_random_hits();
    test_stage_nav();
    test_reset_during_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
